// File: rtl/bfly_combine.sv
// Butterfly combine stage: aligns x with the modular product t and emits (x+t) mod q, (x-t) mod q.
// Optional sticky range/protocol error output is enabled with `define BFLY_ERR_EN.
module bfly_combine #(
  parameter int WIDTH    = 28,
  parameter int MULT_LAT = 6,
  parameter int NUM_BFLY = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] prod_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] even_out,
  output logic [WIDTH-1:0] odd_out,
  output logic             busy,
`ifdef BFLY_ERR_EN
  output logic             err,
`endif
  output logic             done
);

  localparam int CW = $clog2(NUM_BFLY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    in_cnt_r;
  logic [CW-1:0]    out_cnt_r;
  logic             accept_s;
  logic             last_in_s;
  logic             last_out_s;
  logic [WIDTH-1:0] x_sr_r [MULT_LAT];
  logic [MULT_LAT-1:0] v_sr_r;
  logic             v_d_s;
  logic [WIDTH-1:0] x_d_s;
  logic             a_v_r;
  logic [WIDTH:0]   sum_r;
  logic [WIDTH:0]   diff_r;
  logic [WIDTH:0]   even_s;
  logic [WIDTH:0]   odd_s;
  logic             out_valid_r;
  logic [WIDTH-1:0] even_r;
  logic [WIDTH-1:0] odd_r;
  logic             done_r;

  assign accept_s   = in_valid && (state_r == RUN);
  assign last_in_s  = accept_s && (in_cnt_r == CW'(NUM_BFLY - 1));
  assign last_out_s = a_v_r && (out_cnt_r == CW'(NUM_BFLY - 1));
  assign v_d_s      = v_sr_r[MULT_LAT-1];
  assign x_d_s      = x_sr_r[MULT_LAT-1];

  // Next-state logic; done_r is high while still in DRAIN, so a start in that cycle is ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (last_in_s) state_s = DRAIN;
        else           state_s = RUN;
      end
      DRAIN: begin
        if (done_r) state_s = IDLE;
        else        state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and pass counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      in_cnt_r  <= '0;
      out_cnt_r <= '0;
    end else begin
      state_r <= state_s;
      if (state_r == IDLE && start) in_cnt_r <= '0;
      else if (accept_s)            in_cnt_r <= last_in_s ? '0 : in_cnt_r + CW'(1);
      else                          in_cnt_r <= in_cnt_r;
      if (a_v_r) out_cnt_r <= last_out_s ? '0 : out_cnt_r + CW'(1);
      else       out_cnt_r <= out_cnt_r;
    end
  end

  // Delay line matching the multiplier latency; only the valid bits need clearing.
  always_ff @(posedge clk) begin
    x_sr_r[0] <= x_in;
    for (int i = 1; i < MULT_LAT; i++) x_sr_r[i] <= x_sr_r[i-1];
    if (rst) begin
      v_sr_r <= '0;
    end else begin
      v_sr_r[0] <= accept_s;
      for (int i = 1; i < MULT_LAT; i++) v_sr_r[i] <= v_sr_r[i-1];
    end
  end

  // Stage A: raw sum and difference with one guard bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_v_r  <= 1'b0;
      sum_r  <= '0;
      diff_r <= '0;
    end else begin
      a_v_r <= v_d_s;
      if (v_d_s) begin
        sum_r  <= {1'b0, x_d_s} + {1'b0, prod_in};
        diff_r <= {1'b0, x_d_s} - {1'b0, prod_in};
      end else begin
        sum_r  <= sum_r;
        diff_r <= diff_r;
      end
    end
  end

  // Single conditional correction brings both results back into [0, q).
  always_comb begin
    even_s = sum_r;
    odd_s  = diff_r;
    if (sum_r >= {1'b0, q}) even_s = sum_r - {1'b0, q};
    else                    even_s = sum_r;
    if (diff_r[WIDTH]) odd_s = diff_r + {1'b0, q};
    else               odd_s = diff_r;
  end

  // Stage B output registers; data holds while no result is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      even_r      <= '0;
      odd_r       <= '0;
      done_r      <= 1'b0;
    end else begin
      out_valid_r <= a_v_r;
      done_r      <= last_out_s;
      if (a_v_r) begin
        even_r <= even_s[WIDTH-1:0];
        odd_r  <= odd_s[WIDTH-1:0];
      end else begin
        even_r <= even_r;
        odd_r  <= odd_r;
      end
    end
  end

`ifdef BFLY_ERR_EN
  logic err_r;
  logic err_set_s;

  assign err_set_s = (in_valid && state_r != RUN) || (accept_s && x_in >= q) ||
                     (v_d_s && prod_in >= q);

  // Sticky error flag, re-armed by a start accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rst)                        err_r <= 1'b0;
    else if (state_r == IDLE && start) err_r <= err_set_s;
    else                            err_r <= err_r | err_set_s;
  end

  assign err = err_r;
`endif

  assign out_valid = out_valid_r;
  assign even_out  = even_r;
  assign odd_out   = odd_r;
  assign done      = done_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_bfly_combine.sv
// Directed bench for bfly_combine: models the multiplier as a t delay line and
// scoreboards expected outputs with their expected cycle of arrival.
module tb_bfly_combine;
  localparam int W = 28;
  localparam int LAT = 6;
  localparam int NB = 4;
  localparam logic [W-1:0] Q = 28'd268238849;

  typedef struct {
    int         cyc;
    logic [W-1:0] e;
    logic [W-1:0] o;
    bit         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst, start, in_valid;
  logic [W-1:0] x_in, t_in, q, prod_in;
  logic         out_valid, busy, done;
  logic [W-1:0] even_out, odd_out;
`ifdef BFLY_ERR_EN
  logic         err;
`endif
  logic [W-1:0] t_pipe [LAT] = '{default: '0};
  exp_t         sb[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  bfly_combine #(.WIDTH(W), .MULT_LAT(LAT), .NUM_BFLY(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .x_in(x_in),
    .q(q), .prod_in(prod_in), .out_valid(out_valid), .even_out(even_out),
    .odd_out(odd_out), .busy(busy),
`ifdef BFLY_ERR_EN
    .err(err),
`endif
    .done(done));

  always #5 clk = ~clk;

  // Multiplier stand-in: t presented with in_valid shows up LAT cycles later.
  always @(posedge clk) begin
    t_pipe[0] <= t_in;
    for (int i = 1; i < LAT; i++) t_pipe[i] <= t_pipe[i-1];
    cyc <= cyc + 1;
  end
  assign prod_in = t_pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] t);
    logic [63:0] s;
    s = (64'(x) + 64'(t)) % 64'(Q);
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] t);
    logic [63:0] s;
    s = (64'(x) + 64'(Q) - 64'(t)) % 64'(Q);
    return s[W-1:0];
  endfunction

  // One clock of stimulus; accepted inputs schedule an expected output 8 cycles out.
  task automatic drive(input bit st, input bit v, input logic [W-1:0] x,
                       input logic [W-1:0] t, input bit push, input bit last);
    exp_t ex;
    @(negedge clk);
    start = st; in_valid = v; x_in = x; t_in = t;
    if (push) begin
      ex.cyc = cyc + LAT + 2; ex.e = mod_add(x, t); ex.o = mod_sub(x, t); ex.last = last;
      sb.push_back(ex);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 64) begin
      idle(1);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: every out_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t ex;
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          ex = sb.pop_front();
          check("out_cycle", 32'(cyc), 32'(ex.cyc));
          check("even_out", 32'(even_out), 32'(ex.e));
          check("odd_out", 32'(odd_out), 32'(ex.o));
          check("done_with_out", 32'(done), 32'(ex.last));
        end
      end else if (done) begin
        check("done_without_out", 32'(done), 32'd0);
      end
    end
  end

  initial begin
    logic [W-1:0] xs [6];
    logic [W-1:0] ts [6];
    bit           vs [6];
    int           j;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; x_in = '0; t_in = '0; q = Q;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_even", 32'(even_out), 32'd0);
    check("rst_odd", 32'(odd_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);

    // Pass 1: four back-to-back x=5, t=3; a start in the done cycle is ignored.
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 28'd5, 28'd3, 1'b1, 1'b0);
    check("busy_run", 32'(busy), 32'd1);
    drive(1'b0, 1'b1, 28'd5, 28'd3, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 28'd5, 28'd3, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 28'd5, 28'd3, 1'b1, 1'b1);
    idle(7);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    idle(1);
    check("start_at_done_ignored", 32'(busy), 32'd0);
    wait_idle("pass1");

    // Pass 2: boundary values with the gap pattern 1,0,1,1,0,1.
    vs = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    xs = '{28'd0, 28'd0, 28'd268238848, 28'd10, 28'd0, 28'd268238840};
    ts = '{28'd7, 28'd0, 28'd1, 28'd10, 28'd0, 28'd9};
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    j = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, vs[i], xs[i], ts[i], vs[i], vs[i] && j == NB - 1);
      if (vs[i]) j++;
    end
    wait_idle("pass2");

    // Pass 3: t=0 passes x through; reset three cycles after the second accept.
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 28'd123, 28'd0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 28'd456, 28'd0, 1'b1, 1'b0);
    idle(2);
    @(negedge clk);
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    check("busy_after_rst", 32'(busy), 32'd0);
    idle(15);
    check("no_out_after_rst", 32'(out_valid), 32'd0);

    // Pass 4: t=0 and random operands after reset.
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 28'd99, 28'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 1'b1, W'($urandom_range(268238848, 0)), W'($urandom_range(268238848, 0)),
            1'b1, i == 2);
    wait_idle("pass4");

    // Pass 5: in_valid in IDLE is ignored, and start during RUN does not restart counting.
    drive(1'b0, 1'b1, 28'd11, 28'd4, 1'b0, 1'b0);
    idle(1);
`ifdef BFLY_ERR_EN
    check("err_idle_in_valid", 32'(err), 32'd1);
`endif
    check("idle_in_valid_no_busy", 32'(busy), 32'd0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
`ifdef BFLY_ERR_EN
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    check("err_cleared_by_start", 32'(err), 32'd0);
`endif
    drive(1'b0, 1'b1, 28'd20, 28'd30, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 28'd40, 28'd40, 1'b1, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 28'd1000, 28'd1, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 28'd7, 28'd268238000, 1'b1, 1'b1);
    wait_idle("pass5");
    idle(12);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
